// File: rtl/mem_arbiter.sv
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (instruction fetch / data) arbiter in front of a
//               single-outstanding-transaction memory port. Data normally
//               wins; a waiting instruction fetch is forced through after
//               STARVE_LIMIT consecutive data grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,

    // Instruction fetch requester
    input  logic                    i_instr_req_en,
    input  logic [`ADDR_W-1:0]      i_instr_req_addr,
    output logic [`WORD_W-1:0]      o_instr_res_data,
    output logic                    o_instr_res_valid,
    output logic                    o_instr_stall,

    // Data requester
    input  logic                    i_data_req_en,
    input  logic [`ADDR_W-1:0]      i_data_req_addr,
    input  logic [`WORD_W-1:0]      i_data_req_wr_data,
    input  logic                    i_data_req_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_data_req_count,
    output logic [`WORD_W-1:0]      o_data_res_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_data_res_code,
    output logic                    o_data_res_valid,
    output logic                    o_data_stall,

    // Memory request channel
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic [`ADDR_W-1:0]      o_mem_req_addr,
    output logic [`WORD_W-1:0]      o_mem_req_wr_data,
    output logic                    o_mem_req_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_mem_req_count,

    // Memory response channel
    input  logic                    i_mem_res_valid,
    input  logic [`WORD_W-1:0]      i_mem_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]  i_mem_res_code
);

    localparam int CW = `MEM_COUNT_W;

    // Saturation point of the starvation counter, in counter width
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state;
    logic       owner;
    logic [3:0] starve_cnt;

    logic       grant_data;
    logic       grant_instr;
    logic       instr_starved;

    // Arbitration: data has priority unless the instruction side has waited
    // through the full allowance of data grants.
    always_comb begin
        grant_data    = 1'b0;
        grant_instr   = 1'b0;
        instr_starved = i_instr_req_en && (starve_cnt == LIMIT);
        if (i_data_req_en && !instr_starved) begin
            grant_data = 1'b1;
        end else if (i_instr_req_en) begin
            grant_instr = 1'b1;
        end
    end

    // Stall is the requester's own enable masked by its response pulse.
    assign o_instr_stall = i_instr_req_en & ~o_instr_res_valid;
    assign o_data_stall  = i_data_req_en  & ~o_data_res_valid;

    // Arbiter FSM: grant, present request until accepted, await response.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            owner              <= OWNER_INSTR;
            starve_cnt         <= 4'd0;
            o_mem_req_valid    <= 1'b0;
            o_mem_req_addr     <= '0;
            o_mem_req_wr_data  <= '0;
            o_mem_req_wr_en    <= 1'b0;
            o_mem_req_count    <= '0;
            o_instr_res_data   <= '0;
            o_instr_res_valid  <= 1'b0;
            o_data_res_rd_data <= '0;
            o_data_res_code    <= '0;
            o_data_res_valid   <= 1'b0;
        end else begin
            // Response valids are single-cycle pulses
            o_instr_res_valid <= 1'b0;
            o_data_res_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state             <= REQ;
                        owner             <= OWNER_DATA;
                        o_mem_req_valid   <= 1'b1;
                        o_mem_req_addr    <= i_data_req_addr;
                        o_mem_req_wr_data <= i_data_req_wr_data;
                        o_mem_req_wr_en   <= i_data_req_wr_en;
                        o_mem_req_count   <= i_data_req_count;
                        // Only count data grants that made a fetch wait
                        if (i_instr_req_en && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_instr) begin
                        state             <= REQ;
                        owner             <= OWNER_INSTR;
                        o_mem_req_valid   <= 1'b1;
                        o_mem_req_addr    <= i_instr_req_addr;
                        o_mem_req_wr_data <= '0;
                        o_mem_req_wr_en   <= 1'b0;
                        o_mem_req_count   <= CW'(1);
                        starve_cnt        <= 4'd0;
                    end
                end

                REQ: begin
                    // Fields stay latched while memory back-pressures
                    if (i_mem_req_ready) begin
                        state           <= WAIT;
                        o_mem_req_valid <= 1'b0;
                    end
                end

                WAIT: begin
                    // Response goes to the owner even if it dropped its enable
                    if (i_mem_res_valid) begin
                        state <= IDLE;
                        if (owner == OWNER_DATA) begin
                            o_data_res_rd_data <= i_mem_res_rd_data;
                            o_data_res_code    <= i_mem_res_code;
                            o_data_res_valid   <= 1'b1;
                        end else begin
                            o_instr_res_data   <= i_mem_res_rd_data;
                            o_instr_res_valid  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state           <= IDLE;
                    o_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter; the bench plays
//               both requesters and the memory, with a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic                    clk;
    logic                    aresetn;
    logic                    instr_req_en;
    logic [`ADDR_W-1:0]      instr_req_addr;
    logic [`WORD_W-1:0]      instr_res_data;
    logic                    instr_res_valid;
    logic                    instr_stall;
    logic                    data_req_en;
    logic [`ADDR_W-1:0]      data_req_addr;
    logic [`WORD_W-1:0]      data_req_wr_data;
    logic                    data_req_wr_en;
    logic [`MEM_COUNT_W-1:0] data_req_count;
    logic [`WORD_W-1:0]      data_res_rd_data;
    logic [`MEM_CODE_W-1:0]  data_res_code;
    logic                    data_res_valid;
    logic                    data_stall;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [`ADDR_W-1:0]      mem_req_addr;
    logic [`WORD_W-1:0]      mem_req_wr_data;
    logic                    mem_req_wr_en;
    logic [`MEM_COUNT_W-1:0] mem_req_count;
    logic                    mem_res_valid;
    logic [`WORD_W-1:0]      mem_res_rd_data;
    logic [`MEM_CODE_W-1:0]  mem_res_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit                     is_data;
        logic [`WORD_W-1:0]     data;
        logic [`MEM_CODE_W-1:0] code;
    } resp_t;

    resp_t resp_q[$];
    bit    owner_q[$];

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .i_instr_req_en     (instr_req_en),
        .i_instr_req_addr   (instr_req_addr),
        .o_instr_res_data   (instr_res_data),
        .o_instr_res_valid  (instr_res_valid),
        .o_instr_stall      (instr_stall),
        .i_data_req_en      (data_req_en),
        .i_data_req_addr    (data_req_addr),
        .i_data_req_wr_data (data_req_wr_data),
        .i_data_req_wr_en   (data_req_wr_en),
        .i_data_req_count   (data_req_count),
        .o_data_res_rd_data (data_res_rd_data),
        .o_data_res_code    (data_res_code),
        .o_data_res_valid   (data_res_valid),
        .o_data_stall       (data_stall),
        .o_mem_req_valid    (mem_req_valid),
        .i_mem_req_ready    (mem_req_ready),
        .o_mem_req_addr     (mem_req_addr),
        .o_mem_req_wr_data  (mem_req_wr_data),
        .o_mem_req_wr_en    (mem_req_wr_en),
        .o_mem_req_count    (mem_req_count),
        .i_mem_res_valid    (mem_res_valid),
        .i_mem_res_rd_data  (mem_res_rd_data),
        .i_mem_res_code     (mem_res_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                             input logic we, input logic [3:0] cnt, input bit chk_wd);
        check({tag, "_valid"}, mem_req_valid, 1'b1);
        check({tag, "_addr"},  mem_req_addr, addr);
        check({tag, "_wr_en"}, mem_req_wr_en, we);
        check({tag, "_count"}, mem_req_count, cnt);
        if (chk_wd) check({tag, "_wr_data"}, mem_req_wr_data, wd);
    endtask

    // Pop the oldest expected response and compare it to the current pulse
    task automatic check_pulse(input string tag);
        resp_t e;
        total++;
        assert (resp_q.size() > 0) else begin
            bad++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end
        if (resp_q.size() > 0) begin
            e = resp_q.pop_front();
            if (e.is_data) begin
                check({tag, "_dvalid"}, data_res_valid, 1'b1);
                check({tag, "_ivalid"}, instr_res_valid, 1'b0);
                check({tag, "_ddata"},  data_res_rd_data, e.data);
                check({tag, "_dcode"},  data_res_code, e.code);
            end else begin
                check({tag, "_ivalid"}, instr_res_valid, 1'b1);
                check({tag, "_dvalid"}, data_res_valid, 1'b0);
                check({tag, "_idata"},  instr_res_data, e.data);
            end
        end
    endtask

    // Bounded wait for a memory request to appear
    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, mem_req_valid, 1'b1);
    endtask

    // Accept the pending request at once, answer one cycle later, check pulse
    task automatic serve(input string tag, input logic [31:0] rdata,
                         input logic [1:0] code, input bit is_data);
        resp_t r;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check({tag, "_wait_valid"}, mem_req_valid, 1'b0);
        mem_res_valid   = 1'b1;
        mem_res_rd_data = rdata;
        mem_res_code    = code;
        r.is_data = is_data;
        r.data    = rdata;
        r.code    = code;
        resp_q.push_back(r);
        tick();
        mem_res_valid = 1'b0;
        check_pulse(tag);
    endtask

    initial begin
        aresetn          = 1'b0;
        instr_req_en     = 1'b0;
        instr_req_addr   = '0;
        data_req_en      = 1'b0;
        data_req_addr    = '0;
        data_req_wr_data = '0;
        data_req_wr_en   = 1'b0;
        data_req_count   = '0;
        mem_req_ready    = 1'b0;
        mem_res_valid    = 1'b0;
        mem_res_rd_data  = '0;
        mem_res_code     = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_addr",  mem_req_addr, 0);
        check("rst_ivalid",    instr_res_valid, 1'b0);
        check("rst_dvalid",    data_res_valid, 1'b0);
        check("rst_idata",     instr_res_data, 0);
        check("rst_ddata",     data_res_rd_data, 0);
        check("rst_dcode",     data_res_code, 0);
        aresetn = 1'b1;
        tick();

        // ---------------- req_en pulse inside IDLE never reaches memory ----
        instr_req_en   = 1'b1;
        instr_req_addr = 32'h0000_0999;
        #2;
        instr_req_en   = 1'b0;
        tick();
        #1;
        check("noreq_valid", mem_req_valid, 1'b0);

        // ---------------- instruction-only read, minimum latency ----------
        instr_req_en   = 1'b1;
        instr_req_addr = 32'h0000_0040;
        #1;
        check("i1_stall_n",  instr_stall, 1'b1);
        check("i1_idle_val", mem_req_valid, 1'b0);
        tick();
        check_req("i1_req", 32'h40, 32'h0, 1'b0, 4'd1, 1'b0);
        check("i1_stall_n1", instr_stall, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("i1_wait_val", mem_req_valid, 1'b0);
        check("i1_stall_n2", instr_stall, 1'b1);
        begin
            resp_t r;
            r.is_data = 1'b0;
            r.data    = 32'hCAFE_0001;
            r.code    = 2'd0;
            resp_q.push_back(r);
        end
        mem_res_valid   = 1'b1;
        mem_res_rd_data = 32'hCAFE_0001;
        tick();
        mem_res_valid = 1'b0;
        check_pulse("i1_resp");
        check("i1_stall_n3", instr_stall, 1'b0);
        instr_req_en = 1'b0;
        tick();
        check("i1_pulse_end", instr_res_valid, 1'b0);
        check("i1_data_hold", instr_res_data, 32'hCAFE_0001);
        check("i1_no_regrant", mem_req_valid, 1'b0);

        // ---------------- starvation: both held continuously --------------
        owner_q = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        instr_req_en     = 1'b1;
        instr_req_addr   = 32'h0000_0200;
        data_req_en      = 1'b1;
        data_req_addr    = 32'h0000_0300;
        data_req_wr_data = 32'hD0D0_0000;
        data_req_wr_en   = 1'b1;
        data_req_count   = 4'd3;
        tick();
        for (int k = 0; k < 10; k++) begin
            bit own;
            wait_req("st");
            own = owner_q.pop_front();
            if (own)
                check_req("st_d", 32'h300, 32'hD0D0_0000, 1'b1, 4'd3, 1'b1);
            else
                check_req("st_i", 32'h200, 32'h0, 1'b0, 4'd1, 1'b0);
            serve("st_resp", 32'hA000_0000 + 32'(k), 2'(k), own);
        end
        instr_req_en = 1'b0;
        data_req_en  = 1'b0;
        tick();
        check("st_idle", mem_req_valid, 1'b0);

        // ---------------- data write under back-pressure ------------------
        data_req_en      = 1'b1;
        data_req_addr    = 32'h0000_0100;
        data_req_wr_data = 32'hDEAD_BEEF;
        data_req_wr_en   = 1'b1;
        data_req_count   = 4'd1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_req("bp_req", 32'h100, 32'hDEAD_BEEF, 1'b1, 4'd1, 1'b1);
            check("bp_no_pulse", data_res_valid, 1'b0);
            mem_res_valid   = (i == 2);
            mem_res_rd_data = 32'hBAD0_BAD0;
            mem_req_ready   = (i == 5);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b0;
        #1;
        check("bp_wait_val", mem_req_valid, 1'b0);
        check("bp_stale",    data_res_valid, 1'b0);
        begin
            resp_t r;
            r.is_data = 1'b1;
            r.data    = 32'h55AA_55AA;
            r.code    = 2'b10;
            resp_q.push_back(r);
        end
        mem_res_valid   = 1'b1;
        mem_res_rd_data = 32'h55AA_55AA;
        mem_res_code    = 2'b10;
        tick();
        mem_res_valid = 1'b0;
        mem_res_code  = 2'b00;
        check_pulse("bp_resp");
        check("bp_stall", data_stall, 1'b0);
        data_req_en = 1'b0;
        tick();

        // ---------------- reset during WAIT ------------------------------
        instr_req_en   = 1'b1;
        instr_req_addr = 32'h0000_0080;
        tick();
        check_req("rw_req", 32'h80, 32'h0, 1'b0, 4'd1, 1'b0);
        instr_req_en  = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        aresetn = 1'b0;
        #1;
        check("rw_req_valid", mem_req_valid, 1'b0);
        check("rw_req_addr",  mem_req_addr, 0);
        check("rw_idata",     instr_res_data, 0);
        check("rw_ddata",     data_res_rd_data, 0);
        check("rw_dcode",     data_res_code, 0);
        tick();
        aresetn = 1'b1;
        tick();
        mem_res_valid   = 1'b1;
        mem_res_rd_data = 32'h1234_5678;
        tick();
        mem_res_valid = 1'b0;
        check("rw_no_ipulse", instr_res_valid, 1'b0);
        check("rw_no_dpulse", data_res_valid, 1'b0);
        tick();
        check("rw_no_ipulse2", instr_res_valid, 1'b0);
        check("rw_idata_kept", instr_res_data, 0);
        data_req_en      = 1'b1;
        data_req_addr    = 32'h0000_0044;
        data_req_wr_en   = 1'b0;
        data_req_count   = 4'd2;
        tick();
        wait_req("rw_next");
        check_req("rw_next", 32'h44, 32'h0, 1'b0, 4'd2, 1'b0);
        serve("rw_next_resp", 32'h0000_7777, 2'b01, 1'b1);
        data_req_en = 1'b0;
        tick();

        // ---------------- instruction requester drops after grant --------
        instr_req_en   = 1'b1;
        instr_req_addr = 32'h0000_0060;
        tick();
        check_req("dr_req", 32'h60, 32'h0, 1'b0, 4'd1, 1'b0);
        instr_req_en = 1'b0;
        #1;
        check("dr_stall_drop", instr_stall, 1'b0);
        serve("dr_resp", 32'h0BAD_F00D, 2'b00, 1'b0);
        check("dr_stall_pulse", instr_stall, 1'b0);
        tick();
        check("dr_pulse_end", instr_res_valid, 1'b0);
        check("dr_idle", mem_req_valid, 1'b0);

        check("resp_q_drained", resp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
